// File: rtl/lfsr_checker_pkg.sv
// Shared LFSR definitions: XNOR Fibonacci tap set, checker states and
// the legal-length check used by both generator and checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_VERIFY,
    ST_LOCKED
  } lfsr_state_t;

  localparam int LFSR_MIN_BITS  = 3;
  localparam int LFSR_MAX_BITS  = 32;
  localparam int LFSR_WIDE_BITS = 64;

  function automatic logic lfsr_legal(input int n);
    return (n >= LFSR_MIN_BITS && n <= LFSR_MAX_BITS)
        || (n == LFSR_WIDE_BITS);
  endfunction

  // Tap k (1-based register position) as a one-hot mask.
  function automatic logic [63:0] t(input int k);
    return 64'd1 << (k - 1);
  endfunction

  function automatic logic [63:0] lfsr_taps(input int n);
    logic [63:0] m;
    m = '0;
    case (n)
      3:  m = t(3)  | t(2);
      4:  m = t(4)  | t(3);
      5:  m = t(5)  | t(3);
      6:  m = t(6)  | t(5);
      7:  m = t(7)  | t(6);
      8:  m = t(8)  | t(6)  | t(5)  | t(4);
      9:  m = t(9)  | t(5);
      10: m = t(10) | t(7);
      11: m = t(11) | t(9);
      12: m = t(12) | t(6)  | t(4)  | t(1);
      13: m = t(13) | t(4)  | t(3)  | t(1);
      14: m = t(14) | t(5)  | t(3)  | t(1);
      15: m = t(15) | t(14);
      16: m = t(16) | t(15) | t(13) | t(4);
      17: m = t(17) | t(14);
      18: m = t(18) | t(11);
      19: m = t(19) | t(6)  | t(2)  | t(1);
      20: m = t(20) | t(17);
      21: m = t(21) | t(19);
      22: m = t(22) | t(21);
      23: m = t(23) | t(18);
      24: m = t(24) | t(23) | t(22) | t(17);
      25: m = t(25) | t(22);
      26: m = t(26) | t(6)  | t(2)  | t(1);
      27: m = t(27) | t(5)  | t(2)  | t(1);
      28: m = t(28) | t(25);
      29: m = t(29) | t(27);
      30: m = t(30) | t(6)  | t(4)  | t(1);
      31: m = t(31) | t(28);
      32: m = t(32) | t(22) | t(2)  | t(1);
      64: m = t(64) | t(63) | t(61) | t(60);
      default: m = '0;
    endcase
    return m;
  endfunction

  // v[0] holds R[1]; result is the bit the generator shifts in next.
  function automatic logic lfsr_feedback(
    input int          n,
    input logic [63:0] v
  );
    return ~(^(v & lfsr_taps(n)));
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Stream/status bundle between a PRBS source and lfsr_checker.
// master: drives E/DIN/CLR; slave (checker): drives status outputs.
interface lfsr_checker_if #(
  parameter int ERR_CNT_WIDTH = 16
);
  logic                     E;
  logic                     DIN;
  logic                     CLR;
  logic                     LOCKED;
  logic                     ERR;
  logic                     SYNC_LOSS;
  logic [ERR_CNT_WIDTH-1:0] ERR_COUNT;

  modport master (
    output E, DIN, CLR,
    input  LOCKED, ERR, SYNC_LOSS, ERR_COUNT
  );

  modport slave (
    input  E, DIN, CLR,
    output LOCKED, ERR, SYNC_LOSS, ERR_COUNT
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising XNOR LFSR stream checker: FILL/VERIFY/LOCKED.
// Ports: CLK, RESET (sync, high), bus (slave: E DIN CLR -> status).
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS      = 8,
  parameter int LOCK_COUNT    = 16,
  parameter int LOSS_ERRORS   = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  lfsr_checker_if.slave bus
);

  localparam int FW = $clog2(NUM_BITS + 1);
  localparam int OW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_ERRORS + 1);

  if (!lfsr_legal(NUM_BITS) || LOCK_COUNT < 1
      || LOSS_ERRORS < 1) begin : g_bad_param
    $error("lfsr_checker: unsupported parameters");
  end

  lfsr_state_t              r_state;
  logic [NUM_BITS-1:0]      r_sr;
  logic [FW-1:0]            r_fill;
  logic [OW-1:0]            r_ok;
  logic [BW-1:0]            r_bad;
  logic                     r_locked;
  logic                     r_err;
  logic                     r_sync_loss;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  logic                w_pred;
  logic                w_mis;
  logic [NUM_BITS-1:0] w_sr_din;
  logic [NUM_BITS-1:0] w_sr_pred;
  logic [ERR_CNT_WIDTH-1:0] w_cnt_inc;

  assign w_pred    = lfsr_feedback(NUM_BITS, 64'(r_sr));
  assign w_mis     = bus.DIN != w_pred;
  assign w_sr_din  = {r_sr[NUM_BITS-2:0], bus.DIN};
  assign w_sr_pred = {r_sr[NUM_BITS-2:0], w_pred};
  // A clear in the same cycle as a mismatch restarts the count at 1.
  assign w_cnt_inc = bus.CLR ? ERR_CNT_WIDTH'(1)
                   : (&r_err_cnt) ? r_err_cnt
                   : r_err_cnt + 1'b1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_FILL;
      r_sr        <= '0;
      r_fill      <= '0;
      r_ok        <= '0;
      r_bad       <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_sync_loss <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err       <= 1'b0;
      r_sync_loss <= 1'b0;
      if (bus.CLR) r_err_cnt <= '0;
      if (bus.E) begin
        unique case (r_state)
          ST_FILL: begin
            r_sr <= w_sr_din;
            if (r_fill >= FW'(NUM_BITS - 1)) begin
              // All-ones is the XNOR lockup state: keep testing.
              if (&w_sr_din) begin
                r_fill <= FW'(NUM_BITS);
              end else begin
                r_fill  <= '0;
                r_ok    <= '0;
                r_state <= ST_VERIFY;
              end
            end else begin
              r_fill <= r_fill + 1'b1;
            end
          end
          ST_VERIFY: begin
            r_sr <= w_sr_din;
            if (w_mis) begin
              r_ok    <= '0;
              r_fill  <= '0;
              r_state <= ST_FILL;
            end else if (r_ok == OW'(LOCK_COUNT - 1)) begin
              r_ok     <= '0;
              r_bad    <= '0;
              r_locked <= 1'b1;
              r_state  <= ST_LOCKED;
            end else begin
              r_ok <= r_ok + 1'b1;
            end
          end
          ST_LOCKED: begin
            // Flywheel on the prediction so a flipped bit
            // never pollutes the register.
            r_sr <= w_sr_pred;
            if (w_mis) begin
              r_err     <= 1'b1;
              r_err_cnt <= w_cnt_inc;
              if (r_bad == BW'(LOSS_ERRORS - 1)) begin
                r_sync_loss <= 1'b1;
                r_locked    <= 1'b0;
                r_fill      <= '0;
                r_ok        <= '0;
                r_bad       <= '0;
                r_state     <= ST_FILL;
              end else begin
                r_bad <= r_bad + 1'b1;
              end
            end else begin
              r_bad <= '0;
            end
          end
          default: r_state <= ST_FILL;
        endcase
      end
    end
  end

  assign bus.LOCKED    = r_locked;
  assign bus.ERR       = r_err;
  assign bus.SYNC_LOSS = r_sync_loss;
  assign bus.ERR_COUNT = r_err_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed + table-driven bench for lfsr_checker (N=3, LOCK=4,
// LOSS=3, CNT=2) with a queue scoreboard sampled after each edge.
module tb_lfsr_checker;

  logic clk;
  logic rst;

  lfsr_checker_if #(.ERR_CNT_WIDTH(2)) bus ();

  lfsr_checker #(
    .NUM_BITS     (3),
    .LOCK_COUNT   (4),
    .LOSS_ERRORS  (3),
    .ERR_CNT_WIDTH(2)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       l;
    logic       er;
    logic       sl;
    logic [1:0] cnt;
    string      nm;
  } exp_t;

  typedef struct {
    logic       e;
    logic       din;
    logic       l;
    logic [1:0] cnt;
  } vec_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  // Period-7 output of the N=3 generator seeded 000.
  logic seq [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int   gi = 0;

  task automatic nb(output logic b);
    b  = seq[gi];
    gi = (gi + 1) % 7;
  endtask

  task automatic step(
    input logic       r,
    input logic       e,
    input logic       d,
    input logic       c,
    input logic       l,
    input logic       er,
    input logic       sl,
    input logic [1:0] cnt,
    input string      nm
  );
    exp_t x;
    @(negedge clk);
    rst     = r;
    bus.E   = e;
    bus.DIN = d;
    bus.CLR = c;
    x.l = l; x.er = er; x.sl = sl; x.cnt = cnt; x.nm = nm;
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      n_run++;
      if (bus.LOCKED !== x.l || bus.ERR !== x.er
          || bus.SYNC_LOSS !== x.sl
          || bus.ERR_COUNT !== x.cnt) begin
        n_fail++;
        $display("FAIL %s: got L=%b E=%b S=%b C=%0d want L=%b E=%b S=%b C=%0d",
                 x.nm, bus.LOCKED, bus.ERR, bus.SYNC_LOSS,
                 bus.ERR_COUNT, x.l, x.er, x.sl, x.cnt);
      end
    end
  end

  vec_t tbl [10];

  initial begin
    logic d;
    logic e;
    rst     = 1'b1;
    bus.E   = 1'b0;
    bus.DIN = 1'b0;
    bus.CLR = 1'b0;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 2'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 2'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 2'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 2'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 2'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 2'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 2'd0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 2'd0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 2'd0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 2'd0};

    step(1, 0, 0, 0, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 10; i++)
      step(0, tbl[i].e, tbl[i].din, 0,
           tbl[i].l, 0, 0, tbl[i].cnt, "lock_tbl");
    gi = 0;

    for (int i = 0; i < 100; i++) begin
      e = ($urandom_range(0, 3) != 0);
      d = 1'b0;
      if (e) nb(d);
      step(0, e, d, 0, 1, 0, 0, 0, "clean");
    end

    nb(d);
    step(0, 1, ~d, 0, 1, 1, 0, 1, "inv1");
    for (int i = 0; i < 2; i++) begin
      nb(d);
      step(0, 1, d, 0, 1, 0, 0, 1, "inv1_after");
    end

    nb(d);
    step(0, 1, d, 1, 1, 0, 0, 0, "clr");

    for (int k = 0; k < 5; k++) begin
      nb(d);
      step(0, 1, ~d, 0, 1, 1, 0,
           (k < 2) ? 2'(k + 1) : 2'd3, "iso_err");
      for (int j = 0; j < 2; j++) begin
        nb(d);
        step(0, 1, d, 0, 1, 0, 0,
             (k < 2) ? 2'(k + 1) : 2'd3, "iso_good");
      end
    end

    for (int k = 0; k < 3; k++) begin
      nb(d);
      step(0, 1, ~d, 0, k < 2, 1, k == 2, 3, "burst");
    end
    for (int j = 0; j < 7; j++) begin
      nb(d);
      step(0, 1, d, 0, j == 6, 0, 0, 3, "relock");
    end

    nb(d);
    step(0, 1, ~d, 1, 1, 1, 0, 1, "clr_err");

    nb(d);
    step(1, 1, d, 0, 0, 0, 0, 0, "rst_lock");
    for (int j = 0; j < 7; j++) begin
      nb(d);
      step(0, 1, d, 0, j == 6, 0, 0, 0, "post_rst");
    end

    step(1, 0, 0, 0, 0, 0, 0, 0, "reset2");
    for (int j = 0; j < 50; j++)
      step(0, 1, 1, 0, 0, 0, 0, 0, "ones");

    @(negedge clk);
    bus.E = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
